// File: rtl/calc_pkg.sv
// Shared definitions for the BCD calculator key-entry path.
//   DIG_W      BCD digit width
//   CNT_W      width of the ALU latency down-counter (ALU_LAT up to 7)
//   KEY_*      key codes above the digit range 0-9
//   OP_*       operator encodings driven to the ALU stage
//   state_t    key sequencer FSM states
//   helpers    key classification and key-to-op mapping
package calc_pkg;

    localparam int DIG_W = 4;
    localparam int CNT_W = 3;

    localparam logic [3:0] KEY_ADD = 4'd10;
    localparam logic [3:0] KEY_SUB = 4'd11;
    localparam logic [3:0] KEY_MUL = 4'd12;
    localparam logic [3:0] KEY_EQ  = 4'd13;
    localparam logic [3:0] KEY_CLR = 4'd14;
    localparam logic [3:0] KEY_ILL = 4'd15;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_GOT_D1 = 3'd1,
        ST_GOT_OP = 3'd2,
        ST_GOT_D2 = 3'd3,
        ST_EXEC   = 3'd4,
        ST_SHOW   = 3'd5
    } state_t;

    function automatic logic is_digit(input logic [3:0] key);
        return key <= 4'd9;
    endfunction

    function automatic logic is_op(input logic [3:0] key);
        return (key == KEY_ADD) || (key == KEY_SUB) || (key == KEY_MUL);
    endfunction

    function automatic logic [1:0] key_to_op(input logic [3:0] key);
        case (key)
            KEY_SUB: return OP_SUB;
            KEY_MUL: return OP_MUL;
            default: return OP_ADD;
        endcase
    endfunction

endpackage

// File: rtl/calc_lat_counter.sv
// ALU latency down-counter.
//   clk, rst_n   clock, async active-low reset
//   load         load load_val (takes priority over dec)
//   load_val     start value, ALU_LAT-1
//   dec          count down while asserted, saturating at zero
//   zero         count has reached zero
module calc_lat_counter
    import calc_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/calc_key_sequencer.sv
// Operand/operator entry stage of the single-digit BCD calculator.
// Collects digit -> operator -> digit -> '=', drives the ALU operands,
// waits ALU_LAT cycles and latches the ALU units digit for display.
//   clk, rst_n        clock, async active-low reset
//   key_valid/ready   key handshake; key_code 0-9 digit, 10-12 op, 13 '=', 14 clear, 15 illegal
//   dig1, dig2, op    operands and operator to the ALU, stable during EXEC
//   res_in            ALU result for the selected op
//   res, res_valid    latched result and its freshness flag
//   err               one-cycle pulse for a rejected key
//
// state   | meaning
// IDLE    | waiting for the first digit
// GOT_D1  | first digit held, more digits overwrite it
// GOT_OP  | operator held, more ops overwrite it
// GOT_D2  | second digit held, waiting for '='
// EXEC    | keys blocked, counting down the ALU latency
// SHOW    | result shown; digit restarts, op chains, '=' repeats
module calc_key_sequencer
    import calc_pkg::*;
#(
    parameter int ALU_LAT = 1,
    parameter int DIG_W   = calc_pkg::DIG_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             key_valid,
    input  logic [3:0]       key_code,
    output logic             key_ready,
    output logic [DIG_W-1:0] dig1,
    output logic [DIG_W-1:0] dig2,
    output logic [1:0]       op,
    input  logic [DIG_W-1:0] res_in,
    output logic [DIG_W-1:0] res,
    output logic             res_valid,
    output logic             err
);

    localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(ALU_LAT - 1);

    state_t state;
    logic   acc;
    logic   cnt_load;
    logic   cnt_zero;

    assign acc      = key_valid && key_ready;
    assign cnt_load = acc && (key_code == KEY_EQ) &&
                      ((state == ST_GOT_D2) || (state == ST_SHOW));

    calc_lat_counter #(.W(CNT_W)) u_lat (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val (LAT_LOAD),
        .dec      (state == ST_EXEC),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            dig1      <= '0;
            dig2      <= '0;
            op        <= OP_ADD;
            res       <= '0;
            res_valid <= 1'b0;
            err       <= 1'b0;
            key_ready <= 1'b1;
        end else begin
            err <= 1'b0;
            if (state == ST_EXEC) begin
                if (cnt_zero) begin
                    res       <= res_in;
                    res_valid <= 1'b1;
                    key_ready <= 1'b1;
                    state     <= ST_SHOW;
                end
            end else if (acc) begin
                if (key_code == KEY_CLR) begin
                    state     <= ST_IDLE;
                    dig1      <= '0;
                    dig2      <= '0;
                    op        <= OP_ADD;
                    res       <= '0;
                    res_valid <= 1'b0;
                    key_ready <= 1'b1;
                end else if (key_code == KEY_ILL) begin
                    err <= 1'b1;
                end else begin
                    case (state)
                        ST_IDLE: begin
                            if (is_digit(key_code)) begin
                                dig1  <= DIG_W'(key_code);
                                state <= ST_GOT_D1;
                            end else begin
                                err <= 1'b1;
                            end
                        end
                        ST_GOT_D1: begin
                            if (is_digit(key_code)) begin
                                dig1 <= DIG_W'(key_code);
                            end else if (is_op(key_code)) begin
                                op    <= key_to_op(key_code);
                                state <= ST_GOT_OP;
                            end else begin
                                err <= 1'b1;
                            end
                        end
                        ST_GOT_OP: begin
                            if (is_digit(key_code)) begin
                                dig2  <= DIG_W'(key_code);
                                state <= ST_GOT_D2;
                            end else if (is_op(key_code)) begin
                                op <= key_to_op(key_code);
                            end else begin
                                err <= 1'b1;
                            end
                        end
                        ST_GOT_D2: begin
                            if (is_digit(key_code)) begin
                                dig2 <= DIG_W'(key_code);
                            end else if (key_code == KEY_EQ) begin
                                key_ready <= 1'b0;
                                state     <= ST_EXEC;
                            end else begin
                                err <= 1'b1;
                            end
                        end
                        ST_SHOW: begin
                            res_valid <= 1'b0;
                            if (is_digit(key_code)) begin
                                dig1  <= DIG_W'(key_code);
                                state <= ST_GOT_D1;
                            end else if (is_op(key_code)) begin
                                // chaining: the shown result becomes the first operand
                                dig1  <= res;
                                op    <= key_to_op(key_code);
                                state <= ST_GOT_OP;
                            end else begin
                                key_ready <= 1'b0;
                                state     <= ST_EXEC;
                            end
                        end
                        default: state <= ST_IDLE;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_calc_key_sequencer.sv
module tb_calc_key_sequencer;
    import calc_pkg::*;

    typedef struct {
        int res;
        int cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] key_code = 4'd0;
    logic       kv1 = 1'b0, kv3 = 1'b0;
    logic       kr1, kr3;
    logic [3:0] d1_1, d2_1, res_1, rin_1;
    logic [3:0] d1_3, d2_3, res_3, rin_3;
    logic [1:0] op_1, op_3;
    logic       rv1, rv3, err1, err3;

    int   cyc = 0;
    int   total = 0;
    int   passed = 0;
    int   last_acc = 0;
    exp_t q1[$];
    exp_t q3[$];
    logic rv1_d = 1'b0, rv3_d = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    calc_key_sequencer #(.ALU_LAT(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .key_valid(kv1), .key_code(key_code), .key_ready(kr1),
        .dig1(d1_1), .dig2(d2_1), .op(op_1), .res_in(rin_1), .res(res_1),
        .res_valid(rv1), .err(err1)
    );

    calc_key_sequencer #(.ALU_LAT(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .key_valid(kv3), .key_code(key_code), .key_ready(kr3),
        .dig1(d1_3), .dig2(d2_3), .op(op_3), .res_in(rin_3), .res(res_3),
        .res_valid(rv3), .err(err3)
    );

    function automatic logic [3:0] alu(input logic [3:0] a, input logic [3:0] b, input logic [1:0] o);
        int r;
        case (o)
            2'b00:   r = (int'(a) + int'(b)) % 10;
            2'b01:   r = (int'(a) + 10 - int'(b)) % 10;
            default: r = (int'(a) * int'(b)) % 10;
        endcase
        return 4'(r);
    endfunction

    always_comb rin_1 = alu(d1_1, d2_1, op_1);
    always_comb rin_3 = alu(d1_3, d2_3, op_3);

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic send(input int sel, input int code);
        bit ok = 0;
        @(negedge clk);
        key_code = 4'(code);
        if (sel == 1) kv1 = 1'b1; else kv3 = 1'b1;
        for (int i = 0; i < 30; i++) begin
            if ((sel == 1) ? kr1 : kr3) begin
                last_acc = cyc;
                ok = 1;
                @(posedge clk);
                break;
            end
            @(negedge clk);
        end
        #1;
        kv1 = 1'b0;
        kv3 = 1'b0;
        if (!ok) begin
            total++;
            $display("FAIL key_accept_timeout: dut %0d key %0d never accepted", sel, code);
        end
    endtask

    task automatic press_eq(input int sel, input int exp_res);
        exp_t e;
        send(sel, KEY_EQ);
        e.res = exp_res;
        e.cyc = last_acc + 1 + ((sel == 1) ? 1 : 3);
        if (sel == 1) q1.push_back(e); else q3.push_back(e);
    endtask

    always @(negedge clk) begin : mon1
        exp_t e;
        if (rv1 && !rv1_d) begin
            if (q1.size() == 0) begin
                total++;
                $display("FAIL res1_unexpected: res_valid rose with res %0d, expected no result", res_1);
            end else begin
                e = q1.pop_front();
                chk("res1_value", res_1, e.res);
                chk("res1_cycle", cyc, e.cyc);
            end
        end
        rv1_d = rv1;
    end

    always @(negedge clk) begin : mon3
        exp_t e;
        if (rv3 && !rv3_d) begin
            if (q3.size() == 0) begin
                total++;
                $display("FAIL res3_unexpected: res_valid rose with res %0d, expected no result", res_3);
            end else begin
                e = q3.pop_front();
                chk("res3_value", res_3, e.res);
                chk("res3_cycle", cyc, e.cyc);
            end
        end
        rv3_d = rv3;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int low;
        bit ok;
        repeat (3) @(negedge clk);
        chk("rst_key_ready", kr1, 1);
        chk("rst_res_valid", rv1, 0);
        chk("rst_res", res_1, 0);
        chk("rst_dig1", d1_1, 0);
        chk("rst_op", op_1, 0);
        chk("rst_err", err1, 0);
        rst_n = 1'b1;

        // 3 * 7 = 21 -> 1
        send(1, 3); send(1, KEY_MUL); send(1, 7);
        @(negedge clk);
        chk("t1_dig1", d1_1, 3);
        chk("t1_dig2", d2_1, 7);
        chk("t1_op", op_1, 2);
        press_eq(1, 1);
        repeat (4) @(negedge clk);
        chk("t1_res_valid", rv1, 1);
        chk("t1_res", res_1, 1);

        // 9 * 9 = 81 -> 1, chained * 3 -> 3
        send(1, 9); send(1, KEY_MUL); send(1, 9);
        press_eq(1, 1);
        repeat (4) @(negedge clk);
        send(1, KEY_MUL);
        @(negedge clk);
        chk("t2_chain_dig1", d1_1, 1);
        chk("t2_chain_op", op_1, 2);
        chk("t2_chain_rv", rv1, 0);
        send(1, 3);
        press_eq(1, 3);
        repeat (4) @(negedge clk);

        // clear from GOT_OP, then '=' in IDLE
        send(1, KEY_CLR); send(1, 5); send(1, KEY_ADD); send(1, KEY_CLR);
        @(negedge clk);
        chk("t3_clr_dig1", d1_1, 0);
        chk("t3_clr_op", op_1, 0);
        chk("t3_clr_err", err1, 0);
        chk("t3_clr_res", res_1, 0);
        send(1, KEY_EQ);
        @(negedge clk);
        chk("t3_eq_err", err1, 1);
        @(negedge clk);
        chk("t3_eq_err_end", err1, 0);
        chk("t3_eq_rv", rv1, 0);

        // illegal key in GOT_D1, op in GOT_D2, then 4 - 6 -> 8
        send(1, 4); send(1, KEY_ILL);
        @(negedge clk);
        chk("t4_ill_err", err1, 1);
        chk("t4_ill_dig1", d1_1, 4);
        @(negedge clk);
        chk("t4_ill_err_end", err1, 0);
        send(1, KEY_SUB); send(1, 6); send(1, KEY_ADD);
        @(negedge clk);
        chk("t4_op_err", err1, 1);
        chk("t4_op_dig2", d2_1, 6);
        chk("t4_op_op", op_1, 1);
        @(negedge clk);
        chk("t4_op_err_end", err1, 0);
        press_eq(1, 8);
        repeat (4) @(negedge clk);

        // ALU_LAT=3: 2 + 5 = 7, key held through EXEC
        send(3, 2); send(3, KEY_ADD); send(3, 5);
        press_eq(3, 7);
        key_code = 4'd4;
        kv3 = 1'b1;
        low = 0;
        ok = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (!kr3) low++;
            else begin
                @(posedge clk);
                ok = 1;
                break;
            end
        end
        #1 kv3 = 1'b0;
        chk("t5_ready_low_cycles", low, 3);
        chk("t5_held_key_taken", ok, 1);
        @(negedge clk);
        chk("t5_dig1", d1_3, 4);
        chk("t5_rv_cleared", rv3, 0);
        chk("t5_res_held", res_3, 7);

        // reset during EXEC
        send(3, KEY_ADD); send(3, 1); send(3, KEY_EQ);
        @(negedge clk);
        chk("t6_in_exec", kr3, 0);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_dig1", d1_3, 0);
        chk("t6_rst_dig2", d2_3, 0);
        chk("t6_rst_op", op_3, 0);
        chk("t6_rst_res", res_3, 0);
        chk("t6_rst_rv", rv3, 0);
        chk("t6_rst_ready", kr3, 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("t6_rv_stays_low", rv3, 0);

        chk("q1_drained", q1.size(), 0);
        chk("q3_drained", q3.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
